// File: rtl/reg_ctrl_fsm_if.sv
// Fetch/decode/writeback signal bundle between the register-file control
// unit (master) and its surroundings: instruction memory, ALU and the
// 16x8 register file (slave).
interface reg_ctrl_fsm_if #(
    parameter int PC_W = 8
);
    // Instruction fetch handshake
    logic [15:0]     InstrIn;
    logic            InstrValid;
    logic            InstrReq;
    logic [PC_W-1:0] InstrAddr;

    // ALU status and control
    logic            AluZero;
    logic [3:0]      AluOp;

    // Register file control
    logic            RegFileRead;
    logic            RegFileWrite;
    logic [3:0]      Source1;
    logic [3:0]      Source2;
    logic [3:0]      Destin;
    logic            WbSelImm;
    logic [7:0]      Imm;

    // Status
    logic            IllegalOp;
    logic            Halted;

    modport master (
        input  InstrIn, InstrValid, AluZero,
        output InstrReq, InstrAddr, AluOp, RegFileRead, RegFileWrite,
               Source1, Source2, Destin, WbSelImm, Imm, IllegalOp, Halted
    );

    modport slave (
        output InstrIn, InstrValid, AluZero,
        input  InstrReq, InstrAddr, AluOp, RegFileRead, RegFileWrite,
               Source1, Source2, Destin, WbSelImm, Imm, IllegalOp, Halted
    );
endinterface

// File: rtl/reg_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit CPU. Fetches 16-bit instructions,
// decodes them, sequences the register file strobes and selects, drives the
// ALU opcode and writeback mux, and owns the program counter.
// Every output is a flop updated together with the state, so each output
// value is the one belonging to the state being entered.
module reg_ctrl_fsm #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic           clk,
    input  logic           Reset,
    reg_ctrl_fsm_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU ops (1..8), LDI and MOV all finish with a register write.
    function automatic logic is_wb_op(input logic [3:0] op);
        logic r;
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
            4'h6, 4'h7, 4'h8, 4'h9, 4'hA: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

    // Opcodes D and E have no defined meaning.
    function automatic logic is_illegal_op(input logic [3:0] op);
        logic r;
        case (op)
            4'hD, 4'hE: r = 1'b1;
            default:    r = 1'b0;
        endcase
        return r;
    endfunction

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic [15:0]     ir_r;

    logic            instr_req_r;
    logic            reg_file_read_r;
    logic            reg_file_write_r;
    logic [3:0]      source1_r;
    logic [3:0]      source2_r;
    logic [3:0]      destin_r;
    logic [3:0]      alu_op_r;
    logic            wb_sel_imm_r;
    logic            illegal_op_r;
    logic            halted_r;

    logic [3:0]      ir_op_s;
    logic [3:0]      ir_rd_s;
    logic [7:0]      ir_imm_s;
    logic [3:0]      in_op_s;

    assign ir_op_s  = ir_r[15:12];
    assign ir_rd_s  = ir_r[11:8];
    assign ir_imm_s = ir_r[7:0];
    assign in_op_s  = bus.InstrIn[15:12];

    // Sequencer: state, PC, IR and all registered control outputs.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_r          <= ST_FETCH;
            pc_r             <= RESET_PC;
            ir_r             <= 16'h0000;
            instr_req_r      <= 1'b1;
            reg_file_read_r  <= 1'b0;
            reg_file_write_r <= 1'b0;
            source1_r        <= 4'h0;
            source2_r        <= 4'h0;
            destin_r         <= 4'h0;
            alu_op_r         <= 4'h0;
            wb_sel_imm_r     <= 1'b0;
            illegal_op_r     <= 1'b0;
            halted_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (bus.InstrValid) begin
                        // Capture the instruction and present operand selects
                        // so the register file is read during DECODE.
                        ir_r            <= bus.InstrIn;
                        pc_r            <= pc_r + PC_W'(1'b1);
                        state_r         <= ST_DECODE;
                        instr_req_r     <= 1'b0;
                        reg_file_read_r <= 1'b1;
                        if (in_op_s == OP_BEQZ) begin
                            source1_r <= bus.InstrIn[11:8];
                        end else begin
                            source1_r <= bus.InstrIn[7:4];
                        end
                        source2_r       <= bus.InstrIn[3:0];
                    end else begin
                        // Unbounded wait for instruction memory.
                        state_r     <= ST_FETCH;
                        instr_req_r <= 1'b1;
                    end
                end

                ST_DECODE: begin
                    state_r      <= ST_EXEC;
                    alu_op_r     <= ir_op_s;
                    illegal_op_r <= is_illegal_op(ir_op_s);
                end

                ST_EXEC: begin
                    illegal_op_r <= 1'b0;
                    if (is_wb_op(ir_op_s)) begin
                        // Sources and AluOp stay put so the ALU result is
                        // still valid while it is written back.
                        state_r          <= ST_WB;
                        reg_file_write_r <= 1'b1;
                        destin_r         <= ir_rd_s;
                        wb_sel_imm_r     <= (ir_op_s == OP_LDI);
                    end else if (ir_op_s == OP_HALT) begin
                        state_r         <= ST_HALT;
                        halted_r        <= 1'b1;
                        instr_req_r     <= 1'b0;
                        reg_file_read_r <= 1'b0;
                        source1_r       <= 4'h0;
                        source2_r       <= 4'h0;
                        alu_op_r        <= 4'h0;
                    end else begin
                        // NOP, branch, jump and illegal opcodes refetch.
                        if (ir_op_s == OP_JMP) begin
                            pc_r <= PC_W'(ir_imm_s);
                        end else if ((ir_op_s == OP_BEQZ) && bus.AluZero) begin
                            pc_r <= PC_W'(ir_imm_s);
                        end else begin
                            pc_r <= pc_r;
                        end
                        state_r         <= ST_FETCH;
                        instr_req_r     <= 1'b1;
                        reg_file_read_r <= 1'b0;
                        source1_r       <= 4'h0;
                        source2_r       <= 4'h0;
                        alu_op_r        <= 4'h0;
                    end
                end

                ST_WB: begin
                    state_r          <= ST_FETCH;
                    instr_req_r      <= 1'b1;
                    reg_file_read_r  <= 1'b0;
                    reg_file_write_r <= 1'b0;
                    source1_r        <= 4'h0;
                    source2_r        <= 4'h0;
                    destin_r         <= 4'h0;
                    alu_op_r         <= 4'h0;
                    wb_sel_imm_r     <= 1'b0;
                end

                ST_HALT: begin
                    // Only Reset leaves HALT.
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end

                default: begin
                    // Recover from an unreachable encoding by refetching.
                    state_r          <= ST_FETCH;
                    instr_req_r      <= 1'b1;
                    reg_file_read_r  <= 1'b0;
                    reg_file_write_r <= 1'b0;
                    source1_r        <= 4'h0;
                    source2_r        <= 4'h0;
                    destin_r         <= 4'h0;
                    alu_op_r         <= 4'h0;
                    wb_sel_imm_r     <= 1'b0;
                    illegal_op_r     <= 1'b0;
                    halted_r         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InstrReq     = instr_req_r;
    assign bus.InstrAddr    = pc_r;
    assign bus.RegFileRead  = reg_file_read_r;
    assign bus.RegFileWrite = reg_file_write_r;
    assign bus.Source1      = source1_r;
    assign bus.Source2      = source2_r;
    assign bus.Destin       = destin_r;
    assign bus.AluOp        = alu_op_r;
    assign bus.WbSelImm     = wb_sel_imm_r;
    assign bus.Imm          = ir_imm_s;
    assign bus.IllegalOp    = illegal_op_r;
    assign bus.Halted       = halted_r;

endmodule

// File: tb/tb_reg_ctrl_fsm.sv
// Directed bench for reg_ctrl_fsm: walks LDI, ADD, fetch wait states,
// BEQZ taken/not taken, PC wrap via JMP, illegal opcode, asynchronous reset
// during writeback and HALT, comparing against hand-computed values.
module tb_reg_ctrl_fsm;

    logic clk;
    logic Reset;
    int   n_checks;
    int   n_fail;

    reg_ctrl_fsm_if #(.PC_W(8)) bus ();

    reg_ctrl_fsm #(
        .PC_W     (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one instruction for a single FETCH cycle.
    task automatic fetch(input logic [15:0] instr);
        bus.InstrIn    = instr;
        bus.InstrValid = 1'b1;
        tick();
        bus.InstrValid = 1'b0;
        bus.InstrIn    = 16'h0000;
    endtask

    task automatic check_fetch_idle(input string tag, input logic [7:0] pc);
        check_eq({tag, "_req"},   16'(bus.InstrReq),     16'h0001);
        check_eq({tag, "_addr"},  16'(bus.InstrAddr),    16'(pc));
        check_eq({tag, "_rd"},    16'(bus.RegFileRead),  16'h0000);
        check_eq({tag, "_wr"},    16'(bus.RegFileWrite), 16'h0000);
        check_eq({tag, "_destin"},16'(bus.Destin),       16'h0000);
        check_eq({tag, "_aluop"}, 16'(bus.AluOp),        16'h0000);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        Reset          = 1'b1;
        bus.InstrIn    = 16'h0000;
        bus.InstrValid = 1'b0;
        bus.AluZero    = 1'b0;
        tick();
        tick();

        // Reset values
        check_fetch_idle("rst", 8'h00);
        check_eq("rst_imm",    16'(bus.Imm),       16'h0000);
        check_eq("rst_halted", 16'(bus.Halted),    16'h0000);
        check_eq("rst_ill",    16'(bus.IllegalOp), 16'h0000);
        check_eq("rst_wbsel",  16'(bus.WbSelImm),  16'h0000);
        Reset = 1'b0;
        tick();
        check_fetch_idle("idle", 8'h00);

        // LDI r10,0x55
        fetch(16'h9A55);
        check_eq("ldi_d_pc",   16'(bus.InstrAddr),   16'h0001);
        check_eq("ldi_d_rd",   16'(bus.RegFileRead), 16'h0001);
        check_eq("ldi_d_req",  16'(bus.InstrReq),    16'h0000);
        tick();
        check_eq("ldi_e_aluop",16'(bus.AluOp),        16'h0009);
        check_eq("ldi_e_wr",   16'(bus.RegFileWrite), 16'h0000);
        tick();
        check_eq("ldi_w_wr",   16'(bus.RegFileWrite), 16'h0001);
        check_eq("ldi_w_dst",  16'(bus.Destin),       16'h000A);
        check_eq("ldi_w_sel",  16'(bus.WbSelImm),     16'h0001);
        check_eq("ldi_w_imm",  16'(bus.Imm),          16'h0055);
        tick();
        check_fetch_idle("ldi_f", 8'h01);

        // ADD r3,r1,r2
        fetch(16'h1312);
        check_eq("add_d_s1",   16'(bus.Source1),     16'h0001);
        check_eq("add_d_s2",   16'(bus.Source2),     16'h0002);
        check_eq("add_d_rd",   16'(bus.RegFileRead), 16'h0001);
        check_eq("add_d_aluop",16'(bus.AluOp),       16'h0000);
        tick();
        check_eq("add_e_s1",   16'(bus.Source1),     16'h0001);
        check_eq("add_e_s2",   16'(bus.Source2),     16'h0002);
        check_eq("add_e_aluop",16'(bus.AluOp),       16'h0001);
        tick();
        check_eq("add_w_wr",   16'(bus.RegFileWrite), 16'h0001);
        check_eq("add_w_dst",  16'(bus.Destin),       16'h0003);
        check_eq("add_w_sel",  16'(bus.WbSelImm),     16'h0000);
        check_eq("add_w_aluop",16'(bus.AluOp),        16'h0001);
        check_eq("add_w_s1",   16'(bus.Source1),      16'h0001);
        tick();
        check_fetch_idle("add_f", 8'h02);

        // Fetch wait states: junk on InstrIn must not load while invalid
        bus.InstrIn = 16'h0C77;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("wait_req",  16'(bus.InstrReq),  16'h0001);
            check_eq("wait_addr", 16'(bus.InstrAddr), 16'h0002);
            check_eq("wait_imm",  16'(bus.Imm),       16'h0012);
        end
        fetch(16'h0033);
        check_eq("nop_d_imm",  16'(bus.Imm),       16'h0033);
        check_eq("nop_d_pc",   16'(bus.InstrAddr), 16'h0003);
        tick();
        tick();
        check_fetch_idle("nop_f", 8'h03);

        // BEQZ r4,0x20 taken
        fetch(16'hB420);
        check_eq("bqt_d_s1",   16'(bus.Source1), 16'h0004);
        check_eq("bqt_d_s2",   16'(bus.Source2), 16'h0000);
        bus.AluZero = 1'b1;
        tick();
        check_eq("bqt_e_aluop",16'(bus.AluOp),        16'h000B);
        check_eq("bqt_e_wr",   16'(bus.RegFileWrite), 16'h0000);
        tick();
        bus.AluZero = 1'b0;
        check_fetch_idle("bqt_f", 8'h20);

        // BEQZ r4,0x20 not taken
        fetch(16'hB420);
        tick();
        check_eq("bqn_e_wr",   16'(bus.RegFileWrite), 16'h0000);
        tick();
        check_fetch_idle("bqn_f", 8'h21);

        // JMP 0xFF, then fetch wraps PC to 00
        fetch(16'hC0FF);
        tick();
        tick();
        check_fetch_idle("jmp_f", 8'hFF);
        fetch(16'h0000);
        check_eq("wrap_pc", 16'(bus.InstrAddr), 16'h0000);
        tick();
        tick();

        // Illegal opcode D
        fetch(16'hD123);
        check_eq("ill_d",    16'(bus.IllegalOp), 16'h0000);
        tick();
        check_eq("ill_e",    16'(bus.IllegalOp),    16'h0001);
        check_eq("ill_e_wr", 16'(bus.RegFileWrite), 16'h0000);
        tick();
        check_eq("ill_f",    16'(bus.IllegalOp), 16'h0000);
        check_fetch_idle("ill_f", 8'h01);

        // Asynchronous reset in the middle of WB
        fetch(16'h9A55);
        tick();
        tick();
        check_eq("arst_pre_wr", 16'(bus.RegFileWrite), 16'h0001);
        #2;
        Reset = 1'b1;
        #1;
        check_fetch_idle("arst", 8'h00);
        check_eq("arst_wbsel", 16'(bus.WbSelImm), 16'h0000);
        check_eq("arst_imm",   16'(bus.Imm),      16'h0000);
        tick();
        Reset = 1'b0;
        tick();
        check_fetch_idle("arst_post", 8'h00);

        // HALT persists until Reset, even with instructions offered
        fetch(16'hF000);
        tick();
        tick();
        check_eq("halt_h",   16'(bus.Halted),   16'h0001);
        check_eq("halt_req", 16'(bus.InstrReq), 16'h0000);
        bus.InstrIn    = 16'h9A55;
        bus.InstrValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("halt_hold_h",   16'(bus.Halted),       16'h0001);
            check_eq("halt_hold_req", 16'(bus.InstrReq),     16'h0000);
            check_eq("halt_hold_wr",  16'(bus.RegFileWrite), 16'h0000);
            check_eq("halt_hold_rd",  16'(bus.RegFileRead),  16'h0000);
            check_eq("halt_hold_pc",  16'(bus.InstrAddr),    16'h0001);
        end
        bus.InstrValid = 1'b0;
        Reset = 1'b1;
        #1;
        check_eq("halt_rst_h", 16'(bus.Halted), 16'h0000);
        check_fetch_idle("halt_rst", 8'h00);
        tick();
        Reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
